// File: rtl/teak_action_ctrl_regs.sv
`default_nettype none
//==============================================================================
// Module  : teak_action_ctrl_regs
// Brief   : AXI-lite control/parameter registers driving a Teak action toplevel
//           over go/done/paramaddr/paramdata; CYCLES counter via TEAK_ACTION_CYCLE_COUNT_EN.
// Revision: 1.0
//==============================================================================
module teak_action_ctrl_regs #(
   parameter int NUM_PARAMS = 8,
   parameter int ADDR_W     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_awaddr,
   input  logic [3:0]  s_axi_awcache,
   input  logic [2:0]  s_axi_awprot,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   output logic [1:0]  s_axi_bresp,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   input  logic [31:0] s_axi_araddr,
   input  logic [3:0]  s_axi_arcache,
   input  logic [2:0]  s_axi_arprot,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        go_0Ready,
   input  logic        go_0Stop,
   input  logic        done_0Ready,
   output logic        done_0Stop,
   input  logic        paramaddr_0Ready,
   input  logic [31:0] paramaddr_0Data,
   output logic        paramaddr_0Stop,
   output logic        paramdata_0Ready,
   output logic [31:0] paramdata_0Data,
   input  logic        paramdata_0Stop
);

   localparam int              WA_W        = ADDR_W - 2;
   localparam logic [1:0]      ST_IDLE     = 2'd0;
   localparam logic [1:0]      ST_GO       = 2'd1;
   localparam logic [1:0]      ST_RUN      = 2'd2;
   localparam logic [1:0]      RESP_OKAY   = 2'b00;
   localparam logic [1:0]      RESP_SLVERR = 2'b10;
   localparam logic [WA_W-1:0] WA_CTRL     = '0;

   logic [1:0]  state_q, state_d;
   logic        awready_q, awready_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        done_q, done_d;
   logic        pvalid_q, pvalid_d;
   logic [31:0] pdata_q, pdata_d;
   logic [31:0] param_q [NUM_PARAMS];
   logic [31:0] param_d [NUM_PARAMS];

   logic [WA_W-1:0] wr_word, rd_word;
   logic            wr_fire, rd_fire, start, ctrl_rd;
   logic [31:0]     rd_data, p_lookup;
   logic            rd_err;

   logic unused_ok;
   assign unused_ok = ^{s_axi_awaddr[31:ADDR_W], s_axi_awaddr[1:0], s_axi_awcache, s_axi_awprot,
                        s_axi_araddr[31:ADDR_W], s_axi_araddr[1:0], s_axi_arcache, s_axi_arprot};

   assign wr_word = s_axi_awaddr[ADDR_W-1:2];
   assign rd_word = s_axi_araddr[ADDR_W-1:2];
   assign wr_fire = awready_q & s_axi_awvalid & s_axi_wvalid;
   assign rd_fire = arready_q & s_axi_arvalid;
   assign ctrl_rd = rd_fire & (rd_word == WA_CTRL);

`ifdef TEAK_ACTION_CYCLE_COUNT_EN
   localparam logic [WA_W-1:0] WA_CYCLES = WA_W'(2);
   logic [31:0] cycles_q, cycles_d;

   always_comb begin
      cycles_d = cycles_q;
      if (state_q == ST_IDLE && state_d == ST_GO) begin
         cycles_d = '0;
      end else if (state_q == ST_RUN && cycles_q != 32'hFFFF_FFFF) begin
         cycles_d = cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cycles_q <= '0;
      else        cycles_q <= cycles_d;
   end
`endif

   // Handshake sequencing: one outstanding write and one outstanding read.
   always_comb begin
      awready_d = ~awready_q & ~bvalid_q & s_axi_awvalid & s_axi_wvalid;
      bvalid_d  = wr_fire | (bvalid_q & ~s_axi_bready);
      arready_d = ~arready_q & ~rvalid_q & s_axi_arvalid;
      rvalid_d  = rd_fire | (rvalid_q & ~s_axi_rready);
   end

   always_comb begin
      param_d = param_q;
      bresp_d = bresp_q;
      start   = 1'b0;
      if (wr_fire) begin
         bresp_d = RESP_SLVERR;
         if (wr_word == WA_CTRL) begin
            bresp_d = RESP_OKAY;
            start   = s_axi_wdata[0] & s_axi_wstrb[0];
         end
`ifdef TEAK_ACTION_CYCLE_COUNT_EN
         if (wr_word == WA_CYCLES) bresp_d = RESP_OKAY;
`endif
         // Parameters are frozen while the action owns them.
         for (int i = 0; i < NUM_PARAMS; i++) begin
            if (wr_word == WA_W'(4 + i) && state_q == ST_IDLE) begin
               bresp_d = RESP_OKAY;
               for (int b = 0; b < 4; b++) begin
                  if (s_axi_wstrb[b]) param_d[i][8*b +: 8] = s_axi_wdata[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b1;
      if (rd_word == WA_CTRL) begin
         rd_data = {29'd0, state_q == ST_IDLE, done_q, state_q != ST_IDLE};
         rd_err  = 1'b0;
      end
`ifdef TEAK_ACTION_CYCLE_COUNT_EN
      if (rd_word == WA_CYCLES) begin
         rd_data = cycles_q;
         rd_err  = 1'b0;
      end
`endif
      for (int i = 0; i < NUM_PARAMS; i++) begin
         if (rd_word == WA_W'(4 + i)) begin
            rd_data = param_q[i];
            rd_err  = 1'b0;
         end
      end
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      if (rd_fire) begin
         rdata_d = rd_data;
         rresp_d = rd_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

   // A completion landing with a CTRL read keeps done set; the read sees the old value.
   assign done_d = ((state_q == ST_RUN) & done_0Ready) | (done_q & ~ctrl_rd);

   always_comb begin
      p_lookup = '0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
         if (paramaddr_0Data == 32'(i)) p_lookup = param_q[i];
      end
      pvalid_d = (paramaddr_0Ready & ~pvalid_q) | (pvalid_q & paramdata_0Stop);
      pdata_d  = pdata_q;
      if (paramaddr_0Ready & ~pvalid_q) pdata_d = p_lookup;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)        state_d = ST_GO;
         ST_GO:   if (!go_0Stop)    state_d = ST_RUN;
         ST_RUN:  if (done_0Ready)  state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      go_0Ready  = (state_q == ST_GO);
      done_0Stop = reset & (state_q != ST_RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
         done_q    <= 1'b0;
         pvalid_q  <= 1'b0;
         pdata_q   <= '0;
         for (int i = 0; i < NUM_PARAMS; i++) param_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         done_q    <= done_d;
         pvalid_q  <= pvalid_d;
         pdata_q   <= pdata_d;
         param_q   <= param_d;
      end
   end

   assign s_axi_awready    = awready_q;
   assign s_axi_wready     = awready_q;
   assign s_axi_bvalid     = bvalid_q;
   assign s_axi_bresp      = bresp_q;
   assign s_axi_arready    = arready_q;
   assign s_axi_rvalid     = rvalid_q;
   assign s_axi_rdata      = rdata_q;
   assign s_axi_rresp      = rresp_q;
   assign paramaddr_0Stop  = pvalid_q;
   assign paramdata_0Ready = pvalid_q;
   assign paramdata_0Data  = pdata_q;

endmodule
`default_nettype wire

// File: tb/tb_teak_action_ctrl_regs.sv
`default_nettype none
//==============================================================================
// Module  : tb_teak_action_ctrl_regs
// Brief   : Randomized scoreboard bench for teak_action_ctrl_regs.
// Revision: 1.0
//==============================================================================
module tb_teak_action_ctrl_regs;

   localparam int NUM_PARAMS = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic [31:0] s_axi_awaddr, s_axi_wdata;
   logic [3:0]  s_axi_awcache, s_axi_wstrb, s_axi_arcache;
   logic [2:0]  s_axi_awprot, s_axi_arprot;
   logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic [31:0] s_axi_araddr, s_axi_rdata;
   logic        s_axi_rvalid, s_axi_rready;
   logic        go_0Ready, go_0Stop, done_0Ready, done_0Stop;
   logic        paramaddr_0Ready, paramaddr_0Stop, paramdata_0Ready, paramdata_0Stop;
   logic [31:0] paramaddr_0Data, paramdata_0Data;

   always #5 clk = ~clk;

   teak_action_ctrl_regs #(.NUM_PARAMS(NUM_PARAMS), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
      .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
      .s_axi_rresp(s_axi_rresp),
      .go_0Ready(go_0Ready), .go_0Stop(go_0Stop), .done_0Ready(done_0Ready), .done_0Stop(done_0Stop),
      .paramaddr_0Ready(paramaddr_0Ready), .paramaddr_0Data(paramaddr_0Data),
      .paramaddr_0Stop(paramaddr_0Stop), .paramdata_0Ready(paramdata_0Ready),
      .paramdata_0Data(paramdata_0Data), .paramdata_0Stop(paramdata_0Stop)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rd_exp_t;

   int          checks = 0;
   int          failures = 0;
   logic [1:0]  exp_b[$];
   rd_exp_t     exp_r[$];
   logic [31:0] exp_p[$];

   // Reference model state
   logic [31:0] m_param [NUM_PARAMS];
   bit          m_busy, m_done;
   logic [31:0] m_cycles;
   int          cyc = 0;
   int          run_c0 = 0;
   bit          rand_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: timeout (t=%0t)", nm, $time);
   endtask

   // Monitors: pop expectations whenever the DUT completes a response transfer.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (s_axi_bvalid && s_axi_bready) begin
            if (exp_b.size() == 0) fail_now("bresp_unexpected");
            else chk("bresp", {30'd0, s_axi_bresp}, {30'd0, exp_b.pop_front()});
         end
         if (s_axi_rvalid && s_axi_rready) begin
            if (exp_r.size() == 0) fail_now("rresp_unexpected");
            else begin
               rd_exp_t e;
               e = exp_r.pop_front();
               chk("rdata", s_axi_rdata, e.data);
               chk("rresp", {30'd0, s_axi_rresp}, {30'd0, e.resp});
            end
         end
         if (paramdata_0Ready && !paramdata_0Stop) begin
            if (exp_p.size() == 0) fail_now("pdata_unexpected");
            else chk("paramdata", paramdata_0Data, exp_p.pop_front());
         end
      end
   end

   initial begin
      s_axi_bready = 1'b1;
      s_axi_rready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         s_axi_bready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_axi_rready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   function automatic logic [1:0] m_write(input logic [31:0] addr, input logic [31:0] data,
                                          input logic [3:0] strb);
      int w;
      w = int'(addr[7:2]);
      if (w == 0) begin
         if (!m_busy && data[0] && strb[0]) begin
            m_busy   = 1'b1;
            m_cycles = 32'd0;
         end
         return 2'b00;
      end
      if (w == 2) begin
`ifdef TEAK_ACTION_CYCLE_COUNT_EN
         return 2'b00;
`else
         return 2'b10;
`endif
      end
      if (w >= 4 && w < 4 + NUM_PARAMS) begin
         if (m_busy) return 2'b10;
         for (int b = 0; b < 4; b++)
            if (strb[b]) m_param[w-4][8*b +: 8] = data[8*b +: 8];
         return 2'b00;
      end
      return 2'b10;
   endfunction

   function automatic rd_exp_t m_read(input logic [31:0] addr);
      rd_exp_t e;
      int w;
      w = int'(addr[7:2]);
      e.data = 32'd0;
      e.resp = 2'b10;
      if (w == 0) begin
         e.data = {29'd0, !m_busy, m_done, m_busy};
         e.resp = 2'b00;
         m_done = 1'b0;
      end else if (w >= 4 && w < 4 + NUM_PARAMS) begin
         e.data = m_param[w-4];
         e.resp = 2'b00;
      end
`ifdef TEAK_ACTION_CYCLE_COUNT_EN
      else if (w == 2) begin
         e.data = m_cycles;
         e.resp = 2'b00;
      end
`endif
      return e;
   endfunction

   function automatic logic [31:0] mk_addr(input int word);
      logic [31:0] r;
      logic [31:0] wv;
      r  = $urandom();
      wv = 32'(word);
      return {r[31:8], wv[5:0], r[1:0]};
   endfunction

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit ok = 1'b0;
      exp_b.push_back(m_write(addr, data, strb));
      @(posedge clk);
      #1;
      s_axi_awvalid = 1'b1; s_axi_awaddr = addr;
      s_axi_wvalid  = 1'b1; s_axi_wdata  = data; s_axi_wstrb = strb;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_axi_awready && s_axi_wready) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now("aw_accept");
      @(posedge clk);
      #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      for (int c = 0; c < 60 && exp_b.size() != 0; c++) @(negedge clk);
      if (exp_b.size() != 0) begin fail_now("bvalid"); exp_b.delete(); end
   endtask

   task automatic axi_read(input logic [31:0] addr);
      bit ok = 1'b0;
      exp_r.push_back(m_read(addr));
      @(posedge clk);
      #1;
      s_axi_arvalid = 1'b1; s_axi_araddr = addr;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_axi_arready) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now("ar_accept");
      @(posedge clk);
      #1;
      s_axi_arvalid = 1'b0;
      for (int c = 0; c < 60 && exp_r.size() != 0; c++) @(negedge clk);
      if (exp_r.size() != 0) begin fail_now("rvalid"); exp_r.delete(); end
   endtask

   task automatic param_req(input logic [31:0] idx, input int nstop);
      int held = 0;
      bit stop_ok = 1'b1;
      bit ok = 1'b0;
      exp_p.push_back((idx < NUM_PARAMS) ? m_param[idx] : 32'd0);
      @(posedge clk);
      #1;
      paramaddr_0Ready = 1'b1; paramaddr_0Data = idx;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!paramaddr_0Stop) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now("paramaddr_accept");
      @(posedge clk);
      #1;
      paramaddr_0Ready = 1'b0;
      paramdata_0Stop  = (nstop > 0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!paramdata_0Ready) break;
         held++;
         if (!paramaddr_0Stop) stop_ok = 1'b0;
         @(posedge clk);
         #1;
         paramdata_0Stop = (held < nstop);
      end
      paramdata_0Stop = 1'b0;
      chk("pdata_held", 32'(held), 32'(nstop + 1));
      chk("paddr_stop_while_pending", {31'd0, stop_ok}, 32'd1);
      if (exp_p.size() != 0) begin fail_now("paramdata"); exp_p.delete(); end
   endtask

   task automatic start_action(input int nstop);
      int held = 0;
      bit xfer = 1'b0;
      go_0Stop = 1'b1;
      axi_write(mk_addr(0), 32'h1, 4'h1);
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (go_0Ready) begin
            held++;
            go_0Stop = (held <= nstop);
         end else if (held > 0) begin
            xfer = 1'b1;
            break;
         end
      end
      go_0Stop = 1'b1;
      run_c0 = cyc;
      chk("go_held", 32'(held), 32'(nstop + 1));
      chk("go_transfer", {31'd0, xfer}, 32'd1);
      chk("done_stop_in_run", {31'd0, done_0Stop}, 32'd0);
   endtask

   task automatic finish_action(input int wait_cyc);
      repeat (wait_cyc) @(posedge clk);
      #1;
      done_0Ready = 1'b1;
      @(posedge clk);
      #1;
      done_0Ready = 1'b0;
      m_done   = 1'b1;
      m_busy   = 1'b0;
      m_cycles = 32'(cyc - run_c0);
      @(negedge clk);
      chk("idle_go_done_stop", {30'd0, go_0Ready, done_0Stop}, 32'd1);
   endtask

   task automatic rand_op(input bit in_run);
      int op, word;
      logic [31:0] d;
      op = $urandom_range(0, 8);
      if (op <= 3) begin
         word = $urandom_range(0, 15);
         d = $urandom();
         if (word == 0 && !in_run) d[0] = 1'b0;
         axi_write(mk_addr(word), d, 4'($urandom_range(0, 15)));
      end else if (op <= 6) begin
         word = ($urandom_range(0, 5) == 0) ? $urandom_range(16, 63) : $urandom_range(0, 15);
         if (in_run && word == 2) word = 0;
         axi_read(mk_addr(word));
      end else begin
         param_req(($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 11)),
                   $urandom_range(0, 3));
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_PARAMS; i++) m_param[i] = 32'd0;
      m_busy = 1'b0; m_done = 1'b0; m_cycles = 32'd0;
      exp_b.delete(); exp_r.delete(); exp_p.delete();
   endtask

   function automatic logic [31:0] out_or();
      return {31'd0, |{s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                      s_axi_rvalid, s_axi_rdata, s_axi_rresp, go_0Ready, done_0Stop,
                      paramaddr_0Stop, paramdata_0Ready, paramdata_0Data}};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awcache = '0; s_axi_awprot = '0;
      s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arcache = '0; s_axi_arprot = '0;
      go_0Stop = 1'b1; done_0Ready = 1'b0;
      paramaddr_0Ready = 1'b0; paramaddr_0Data = '0; paramdata_0Stop = 1'b0;
      model_reset();

      #23;
      chk("reset_outputs_zero", out_or(), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {30'd0, go_0Ready, done_0Stop}, 32'd1);
      axi_read(mk_addr(0));

      // Byte-enabled parameter write
      axi_write(mk_addr(4), 32'h1234_5678, 4'hF);
      axi_write(mk_addr(4), 32'hDEAD_BEEF, 4'b0011);
      axi_read(mk_addr(4));
      chk("param0_model", m_param[0], 32'h1234_BEEF);

      // Action with go stalled for three cycles and a ten-cycle run
      start_action(3);
      finish_action(9);
      chk("cycles_model", m_cycles, 32'd10);
      axi_read(mk_addr(0));
      axi_read(mk_addr(0));
      axi_read(mk_addr(2));

      // Parameter channel, in-range and out-of-range index
      axi_write(mk_addr(5), 32'hA5A5_0101, 4'hF);
      param_req(32'd1, 2);
      param_req(32'd9, 2);

      // Accesses while the action owns the parameters
      axi_write(mk_addr(7), 32'h0000_0005, 4'hF);
      start_action(0);
      axi_write(mk_addr(7), 32'hFFFF_FFFF, 4'hF);
      axi_read(mk_addr(7));
      axi_read(mk_addr(16));
      axi_read(mk_addr(0));
      axi_write(mk_addr(0), 32'h1, 4'hF);
      param_req(32'd3, 1);
      finish_action(2);

      rand_rdy = 1'b1;
      for (int it = 0; it < 120; it++) begin
         if ($urandom_range(0, 7) == 0) begin
            start_action($urandom_range(0, 3));
            repeat ($urandom_range(0, 4)) rand_op(1'b1);
            finish_action($urandom_range(0, 5));
            axi_read(mk_addr(2));
         end else begin
            rand_op(1'b0);
         end
      end
      rand_rdy = 1'b0;
      repeat (3) @(posedge clk);

      // Asynchronous reset in the middle of a run
      axi_write(mk_addr(6), 32'd5, 4'hF);
      start_action(1);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrun_reset_outputs_zero", out_or(), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      axi_read(mk_addr(6));
      axi_read(mk_addr(0));

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
